// File: rtl/fsm_aspiradora_ctrl_if.sv
// Switch inputs, enable and actuator/status outputs of the robot-vacuum controller.
// The master side drives switches and ena; the slave side is the controller.
interface fsm_aspiradora_ctrl_if #(
   parameter int EVC_W = 3
);
   logic             ena;
   logic             power_off_i;
   logic             power_on_i;
   logic             start_i;
   logic             obstacle_i;
   logic             battery_low_i;
   logic             docked_i;
   logic [2:0]       state_o;
   logic             drive_en_o;
   logic             brush_en_o;
   logic             reverse_o;
   logic             turn_dir_o;
   logic [EVC_W-1:0] evade_cnt_o;

   modport master (
      output ena, power_off_i, power_on_i, start_i, obstacle_i, battery_low_i, docked_i,
      input  state_o, drive_en_o, brush_en_o, reverse_o, turn_dir_o, evade_cnt_o
   );

   modport slave (
      input  ena, power_off_i, power_on_i, start_i, obstacle_i, battery_low_i, docked_i,
      output state_o, drive_en_o, brush_en_o, reverse_o, turn_dir_o, evade_cnt_o
   );
endinterface

// File: rtl/fsm_aspiradora_ctrl.sv
// Robot-vacuum Moore controller: synchronised and debounced switches, timed evade
// manoeuvres with alternating turn direction, cleaning-session timeout and dock return.
module fsm_aspiradora_ctrl #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int EVADE_CYCLES    = 16,
   parameter int CLEAN_CYCLES    = 1024,
   parameter int EVC_W           = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fsm_aspiradora_ctrl_if.slave  bus
);
   localparam int NIN   = 6;
   localparam int DBC_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int CLK_W = $clog2(CLEAN_CYCLES + 1);
   localparam int EVT_W = $clog2(EVADE_CYCLES + 1);

   localparam int I_OFF   = 0;
   localparam int I_ON    = 1;
   localparam int I_START = 2;
   localparam int I_OBS   = 3;
   localparam int I_BAT   = 4;
   localparam int I_DOCK  = 5;

   typedef enum logic [2:0] {
      S_OFF   = 3'd0,
      S_IDLE  = 3'd1,
      S_CLEAN = 3'd2,
      S_EVADE = 3'd3,
      S_DOCK  = 3'd4
   } state_t;

   function automatic logic [EVC_W-1:0] sat_inc(input logic [EVC_W-1:0] v);
      if (&v) return v;
      return v + 1'b1;
   endfunction

   logic [NIN-1:0]   w_raw;
   logic [NIN-1:0]   r_sync [SYNC_STAGES];
   logic [NIN-1:0]   w_sync;
   logic [DBC_W-1:0] r_dbc [NIN];
   logic [NIN-1:0]   r_deb;
   logic [1:0]       r_edge_q;
   logic             w_on_rise;
   logic             w_start_rise;

   state_t           r_state, w_state_nxt;
   logic [CLK_W-1:0] r_clean_tmr, w_clean_nxt;
   logic [EVT_W-1:0] r_evade_tmr, w_evade_nxt;
   logic             r_turn_dir, w_turn_nxt;
   logic [EVC_W-1:0] r_evade_cnt, w_cnt_nxt;
   logic             r_drive_en, r_brush_en, r_reverse;

   assign w_raw = {bus.docked_i, bus.battery_low_i, bus.obstacle_i,
                   bus.start_i, bus.power_on_i, bus.power_off_i};
   assign w_sync = r_sync[SYNC_STAGES-1];

   // Input path runs every cycle, independent of ena
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
         for (int i = 0; i < NIN; i++) r_dbc[i] <= '0;
         r_deb    <= '0;
         r_edge_q <= '0;
      end else begin
         r_sync[0] <= w_raw;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
         for (int i = 0; i < NIN; i++) begin
            if (w_sync[i] == r_deb[i]) begin
               r_dbc[i] <= '0;
            end else if (r_dbc[i] == DBC_W'(DEBOUNCE_CYCLES - 1)) begin
               r_deb[i] <= w_sync[i];
               r_dbc[i] <= '0;
            end else begin
               r_dbc[i] <= r_dbc[i] + 1'b1;
            end
         end
         r_edge_q <= {r_deb[I_START], r_deb[I_ON]};
      end
   end

   // Edge registers track every cycle, so an edge that lands while ena=0 is lost
   assign w_on_rise    = r_deb[I_ON]    & ~r_edge_q[0];
   assign w_start_rise = r_deb[I_START] & ~r_edge_q[1];

   always_comb begin
      w_state_nxt = r_state;
      w_clean_nxt = r_clean_tmr;
      w_evade_nxt = r_evade_tmr;
      w_turn_nxt  = r_turn_dir;
      w_cnt_nxt   = r_evade_cnt;
      if (bus.ena) begin
         if (r_deb[I_OFF]) begin
            w_state_nxt = S_OFF;
            w_clean_nxt = '0;
            w_evade_nxt = '0;
            w_cnt_nxt   = '0;
         end else begin
            case (r_state)
               S_OFF: if (w_on_rise) w_state_nxt = S_IDLE;
               S_IDLE: begin
                  if (w_start_rise && !r_deb[I_BAT]) begin
                     w_state_nxt = S_CLEAN;
                     w_clean_nxt = CLK_W'(CLEAN_CYCLES);
                     w_cnt_nxt   = '0;
                  end
               end
               S_CLEAN: begin
                  if (r_clean_tmr != '0) w_clean_nxt = r_clean_tmr - 1'b1;
                  if (r_deb[I_BAT]) begin
                     w_state_nxt = S_DOCK;
                  end else if (r_deb[I_OBS]) begin
                     w_state_nxt = S_EVADE;
                     w_evade_nxt = EVT_W'(EVADE_CYCLES - 1);
                     w_turn_nxt  = ~r_turn_dir;
                     w_cnt_nxt   = sat_inc(r_evade_cnt);
                  end else if (r_clean_tmr <= CLK_W'(1)) begin
                     w_state_nxt = S_DOCK;
                  end
               end
               S_EVADE: begin
                  if (r_deb[I_BAT]) begin
                     w_state_nxt = S_DOCK;
                  end else if (r_evade_tmr == '0) begin
                     if (r_deb[I_OBS]) begin
                        w_evade_nxt = EVT_W'(EVADE_CYCLES - 1);
                        w_turn_nxt  = ~r_turn_dir;
                        w_cnt_nxt   = sat_inc(r_evade_cnt);
                     end else begin
                        w_state_nxt = S_CLEAN;
                     end
                  end else begin
                     w_evade_nxt = r_evade_tmr - 1'b1;
                  end
               end
               S_DOCK: if (r_deb[I_DOCK]) w_state_nxt = S_IDLE;
               default: w_state_nxt = S_OFF;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_OFF;
         r_clean_tmr <= '0;
         r_evade_tmr <= '0;
         r_turn_dir  <= 1'b0;
         r_evade_cnt <= '0;
         r_drive_en  <= 1'b0;
         r_brush_en  <= 1'b0;
         r_reverse   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_clean_tmr <= w_clean_nxt;
         r_evade_tmr <= w_evade_nxt;
         r_turn_dir  <= w_turn_nxt;
         r_evade_cnt <= w_cnt_nxt;
         r_drive_en  <= (w_state_nxt == S_CLEAN) || (w_state_nxt == S_EVADE) ||
                        (w_state_nxt == S_DOCK);
         r_brush_en  <= (w_state_nxt == S_CLEAN);
         r_reverse   <= (w_state_nxt == S_EVADE);
      end
   end

   assign bus.state_o     = r_state;
   assign bus.drive_en_o  = r_drive_en;
   assign bus.brush_en_o  = r_brush_en;
   assign bus.reverse_o   = r_reverse;
   assign bus.turn_dir_o  = r_turn_dir;
   assign bus.evade_cnt_o = r_evade_cnt;
endmodule

// File: tb/tb_fsm_aspiradora_ctrl.sv
// Directed bench for fsm_aspiradora_ctrl with SYNC=2, DEBOUNCE=4, EVADE=8, CLEAN=64:
// switch-to-state latency 7 cycles, stimulus driven and sampled on the falling edge.
module tb_fsm_aspiradora_ctrl;
   localparam int EVC_W = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   fsm_aspiradora_ctrl_if #(.EVC_W(EVC_W)) bus ();

   fsm_aspiradora_ctrl #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EVADE_CYCLES(8), .CLEAN_CYCLES(64), .EVC_W(EVC_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      bus.ena = 1'b1;
      bus.power_off_i = 1'b0;
      bus.power_on_i = 1'b0;
      bus.start_i = 1'b0;
      bus.obstacle_i = 1'b0;
      bus.battery_low_i = 1'b0;
      bus.docked_i = 1'b0;
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic to_clean();
      do_reset();
      bus.power_on_i = 1'b1;
      tick(7);
      bus.start_i = 1'b1;
      tick(7);
   endtask

   function automatic logic [9:0] all_outs();
      return {bus.state_o, bus.drive_en_o, bus.brush_en_o, bus.reverse_o,
              bus.turn_dir_o, bus.evade_cnt_o};
   endfunction

   task automatic test_reset();
      to_clean();
      do_reset();
      n_cmp++;
      if (all_outs() !== 10'd0) begin
         n_bad++; $display("FAIL reset_outs: got %h expected 000", all_outs());
      end
   endtask

   task automatic test_power_up();
      do_reset();
      bus.power_on_i = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         logic [2:0] exp_st;
         tick(1);
         exp_st = (k < 7) ? 3'd0 : 3'd1;
         n_cmp++;
         if (bus.state_o !== exp_st) begin
            n_bad++; $display("FAIL pwr_state k=%0d: got %0d expected %0d", k, bus.state_o, exp_st);
         end
         n_cmp++;
         if ({bus.drive_en_o, bus.brush_en_o, bus.reverse_o} !== 3'b000) begin
            n_bad++; $display("FAIL pwr_act k=%0d: got %b expected 000", k,
                              {bus.drive_en_o, bus.brush_en_o, bus.reverse_o});
         end
      end
   endtask

   task automatic test_bounce();
      do_reset();
      bus.power_on_i = 1'b1;
      tick(7);
      for (int t = 0; t < 20; t++) begin
         bus.start_i = ((t / 2) % 2 == 0);
         tick(1);
         n_cmp++;
         if (bus.state_o !== 3'd1) begin
            n_bad++; $display("FAIL bounce_hold t=%0d: got %0d expected 1", t, bus.state_o);
         end
      end
      bus.start_i = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         logic [2:0] exp_st;
         tick(1);
         exp_st = (k < 7) ? 3'd1 : 3'd2;
         n_cmp++;
         if (bus.state_o !== exp_st) begin
            n_bad++; $display("FAIL bounce_settle k=%0d: got %0d expected %0d", k, bus.state_o, exp_st);
         end
      end
   endtask

   task automatic test_full_session();
      int n_clean = 0;
      to_clean();
      for (int g = 0; g < 200 && bus.state_o == 3'd2; g++) begin
         n_cmp++;
         if (bus.brush_en_o !== 1'b1) begin
            n_bad++; $display("FAIL session_brush c=%0d: got %b expected 1", g, bus.brush_en_o);
         end
         n_clean++;
         tick(1);
      end
      n_cmp++;
      if (n_clean != 64) begin
         n_bad++; $display("FAIL session_len: got %0d expected 64", n_clean);
      end
      n_cmp++;
      if ({bus.state_o, bus.drive_en_o, bus.brush_en_o} !== {3'd4, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL session_dock: got %b expected 10010", {bus.state_o, bus.drive_en_o, bus.brush_en_o});
      end
      bus.docked_i = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         logic [2:0] exp_st;
         tick(1);
         exp_st = (k < 7) ? 3'd4 : 3'd1;
         n_cmp++;
         if (bus.state_o !== exp_st) begin
            n_bad++; $display("FAIL docked k=%0d: got %0d expected %0d", k, bus.state_o, exp_st);
         end
      end
      bus.docked_i = 1'b0;
   endtask

   task automatic test_evade();
      int e0 = -1;
      int n_clean = 0;
      int n_ev = 0;
      to_clean();
      for (int c = 0; c < 300 && bus.state_o != 3'd4; c++) begin
         if (bus.state_o == 3'd2) n_clean++;
         if (bus.state_o == 3'd3) begin
            if (e0 < 0) e0 = c;
            n_ev++;
         end
         if (c == 10 || c == 17 || c == 18 || c == 26) begin
            logic [7:0] exp_v;
            case (c)
               10:      exp_v = {3'd3, 1'b1, 1'b1, 3'd1};
               17:      exp_v = {3'd3, 1'b1, 1'b1, 3'd1};
               18:      exp_v = {3'd3, 1'b1, 1'b0, 3'd2};
               default: exp_v = {3'd2, 1'b0, 1'b0, 3'd2};
            endcase
            n_cmp++;
            if ({bus.state_o, bus.reverse_o, bus.turn_dir_o, bus.evade_cnt_o} !== exp_v) begin
               n_bad++; $display("FAIL evade_c%0d: got %b expected %b", c,
                                 {bus.state_o, bus.reverse_o, bus.turn_dir_o, bus.evade_cnt_o}, exp_v);
            end
         end
         bus.obstacle_i = (c >= 3 && c < 13);
         tick(1);
      end
      n_cmp++;
      if (e0 != 10) begin
         n_bad++; $display("FAIL evade_entry: got %0d expected 10", e0);
      end
      n_cmp++;
      if (n_ev != 16) begin
         n_bad++; $display("FAIL evade_len: got %0d expected 16", n_ev);
      end
      n_cmp++;
      if (n_clean != 64) begin
         n_bad++; $display("FAIL evade_clean_total: got %0d expected 64", n_clean);
      end
      n_cmp++;
      if ({bus.state_o, bus.evade_cnt_o} !== {3'd4, 3'd2}) begin
         n_bad++; $display("FAIL evade_end: got %b expected 100010", {bus.state_o, bus.evade_cnt_o});
      end
   endtask

   task automatic test_priority();
      to_clean();
      tick(2);
      bus.battery_low_i = 1'b1;
      bus.obstacle_i = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         logic [2:0] exp_st;
         tick(1);
         exp_st = (k < 7) ? 3'd2 : 3'd4;
         n_cmp++;
         if (bus.state_o !== exp_st) begin
            n_bad++; $display("FAIL prio_bat k=%0d: got %0d expected %0d", k, bus.state_o, exp_st);
         end
      end
      bus.battery_low_i = 1'b0;
      bus.obstacle_i = 1'b0;
   endtask

   task automatic test_saturate_poweroff();
      to_clean();
      bus.obstacle_i = 1'b1;
      tick(7);
      n_cmp++;
      if (bus.state_o !== 3'd3) begin
         n_bad++; $display("FAIL sat_entry: got %0d expected 3", bus.state_o);
      end
      tick(70);
      n_cmp++;
      if ({bus.state_o, bus.turn_dir_o, bus.evade_cnt_o} !== {3'd3, 1'b1, 3'd7}) begin
         n_bad++; $display("FAIL sat_cnt: got %b expected 0111111", {bus.state_o, bus.turn_dir_o, bus.evade_cnt_o});
      end
      bus.power_off_i = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         logic [2:0] exp_st;
         tick(1);
         exp_st = (k < 7) ? 3'd3 : 3'd0;
         n_cmp++;
         if (bus.state_o !== exp_st) begin
            n_bad++; $display("FAIL poweroff k=%0d: got %0d expected %0d", k, bus.state_o, exp_st);
         end
      end
      n_cmp++;
      if ({bus.drive_en_o, bus.brush_en_o, bus.reverse_o, bus.evade_cnt_o} !== 6'd0) begin
         n_bad++; $display("FAIL poweroff_outs: got %b expected 000000",
                           {bus.drive_en_o, bus.brush_en_o, bus.reverse_o, bus.evade_cnt_o});
      end
      bus.power_off_i = 1'b0;
      bus.obstacle_i = 1'b0;
   endtask

   task automatic test_ena_hold();
      int n_ev;
      int n_clean = 0;
      to_clean();
      bus.obstacle_i = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick(1);
         if (k == 5) bus.obstacle_i = 1'b0;
      end
      n_cmp++;
      if (bus.state_o !== 3'd3) begin
         n_bad++; $display("FAIL hold_entry: got %0d expected 3", bus.state_o);
      end
      bus.ena = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick(1);
         n_cmp++;
         if ({bus.state_o, bus.reverse_o, bus.turn_dir_o, bus.evade_cnt_o} !== {3'd3, 1'b1, 1'b1, 3'd1}) begin
            n_bad++; $display("FAIL hold_frozen k=%0d: got %b expected 01111001", k,
                              {bus.state_o, bus.reverse_o, bus.turn_dir_o, bus.evade_cnt_o});
         end
      end
      bus.ena = 1'b1;
      n_ev = 21;
      for (int g = 0; g < 100 && bus.state_o == 3'd3; g++) begin
         tick(1);
         if (bus.state_o == 3'd3) n_ev++;
      end
      n_cmp++;
      if (n_ev != 28) begin
         n_bad++; $display("FAIL hold_evade_len: got %0d expected 28", n_ev);
      end
      for (int g = 0; g < 200 && bus.state_o == 3'd2; g++) begin
         n_clean++;
         tick(1);
      end
      n_cmp++;
      if (n_clean != 57) begin
         n_bad++; $display("FAIL hold_clean_rest: got %0d expected 57", n_clean);
      end

      do_reset();
      bus.power_on_i = 1'b1;
      tick(7);
      bus.ena = 1'b0;
      bus.start_i = 1'b1;
      tick(15);
      bus.ena = 1'b1;
      tick(10);
      n_cmp++;
      if (bus.state_o !== 3'd1) begin
         n_bad++; $display("FAIL hold_start_ignored: got %0d expected 1", bus.state_o);
      end
   endtask

   task automatic test_async_reset();
      to_clean();
      tick(5);
      n_cmp++;
      if (bus.state_o !== 3'd2) begin
         n_bad++; $display("FAIL areset_pre: got %0d expected 2", bus.state_o);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (all_outs() !== 10'd0) begin
         n_bad++; $display("FAIL areset_outs: got %h expected 000", all_outs());
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_power_up();
      test_bounce();
      test_full_session();
      test_evade();
      test_priority();
      test_saturate_poweroff();
      test_ena_hold();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fsm_aspiradora_ctrl.md
Name: fsm_aspiradora_ctrl

Overview:
Parametrised next-generation robot-vacuum controller: a Moore FSM (OFF, IDLE, CLEAN, EVADE, DOCK) with timed behaviour that the fixed 4-state design lacks. Per-input synchronisers and debouncers, a timed evade manoeuvre with alternating turn direction, a cleaning-session timeout, and battery-low return-to-dock. Sits behind the tt_um top wrapper: switches come from ui_in, and state and actuator flags drive uo_out.

Parameters:
SYNC_STAGES, 2, synchroniser flops per raw input (>=2)
DEBOUNCE_CYCLES, 8, consecutive stable synchronised cycles before the debounced level changes (>=1)
EVADE_CYCLES, 16, cycles spent in EVADE per manoeuvre (>=1)
CLEAN_CYCLES, 1024, total CLEAN cycles per session before the automatic return to dock (>=1)
EVC_W, 3, width of the saturating evade counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  FSM/timer advance enable; low = hold
power_off_i  in  1  raw switch, level: force OFF
power_on_i  in  1  raw switch, rising edge: OFF->IDLE
start_i  in  1  raw switch, rising edge: IDLE->CLEAN
obstacle_i  in  1  raw bumper, level
battery_low_i  in  1  raw, level
docked_i  in  1  raw, level
state_o  out  3  OFF=0 IDLE=1 CLEAN=2 EVADE=3 DOCK=4
drive_en_o  out  1  wheel motors on
brush_en_o  out  1  brush motor on
reverse_o  out  1  reversing (evade)
turn_dir_o  out  1  0=left, 1=right for the current or last evade
evade_cnt_o  out  EVC_W  evades in the current session, saturating

Behaviour:
- Reset (async assert, sync release): state OFF; all outputs 0; synchronisers, debounced levels, edge registers, timers and evade counter cleared.
- Input path: raw input -> SYNC_STAGES flops -> debouncer.
  - Debounced level flips only after the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce resets the debounce count.
  - Raw edge to state_o change: exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles.
  - The input path runs regardless of ena.
- Edge detect: power_on and start act on the rising edge of the debounced level. An edge seen while ena=0 is discarded.
- ena=0: state, timers, turn_dir and evade_cnt hold.
- Transitions are evaluated each ena=1 cycle, highest priority first:
  - Any state, power_off high -> OFF. Timers and evade_cnt cleared.
  - OFF: power_on edge -> IDLE.
  - IDLE: start edge with battery_low low -> CLEAN. Load clean timer with CLEAN_CYCLES; clear evade_cnt. A start edge while battery_low is high is ignored.
  - CLEAN (clean timer decrements by 1 per cycle in CLEAN):
    - battery_low high -> DOCK.
    - Otherwise obstacle high -> EVADE. Load evade timer with EVADE_CYCLES-1; toggle turn_dir; increment evade_cnt (saturates at 2^EVC_W-1).
    - Otherwise, if the clean timer equals 1 this cycle -> DOCK.
  - EVADE (evade timer decrements in EVADE; clean timer frozen, not reloaded):
    - battery_low high -> DOCK.
    - Timer at 0 and obstacle low -> CLEAN, resuming the remaining clean time.
    - Timer at 0 and obstacle still high -> stay in EVADE. Reload timer; toggle turn_dir; increment evade_cnt.
  - DOCK: docked high -> IDLE.
- Moore outputs, registered with state:
  - drive_en = CLEAN|EVADE|DOCK.
  - brush_en = CLEAN.
  - reverse = EVADE.
  - turn_dir and evade_cnt hold their values outside EVADE.
- Simultaneous events follow the priority order above; e.g. obstacle and timeout in the same CLEAN cycle -> EVADE.
- Reset mid-operation returns to OFF immediately, with no residual timer state.
- Encodings 5-7 are unreachable; if decoded, the next state is OFF.

Test Plan:
All tests use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EVADE_CYCLES=8, CLEAN_CYCLES=64, EVC_W=3, ena=1.
- Power-up: reset, then power_on_i 0->1 held. state_o goes 0->1 exactly 7 cycles after the edge, and all actuator outputs stay 0.
- Bounce rejection: start_i toggles every 2 cycles for 20 cycles, then settles high. CLEAN is entered exactly 7 cycles after the final edge and never earlier.
- Full session: start, no obstacle. CLEAN for exactly 64 cycles with brush_en_o=1, then state_o=4. Raise docked_i -> state_o=1 after 7 cycles.
- Evade: obstacle pulse of 10 cycles during CLEAN. EVADE entered with reverse_o=1, turn_dir_o=1, evade_cnt_o=1, lasting 8 cycles. A second manoeuvre follows because the obstacle is still high at expiry (turn_dir_o=0, evade_cnt_o=2). Then CLEAN resumes, and total CLEAN cycles across the session still equal 64.
- Priority: battery_low_i and obstacle_i rise together in CLEAN -> DOCK with no EVADE. power_off_i in EVADE -> OFF, evade_cnt_o=0. Nine evades -> evade_cnt_o saturates at 7.
- ena hold and async reset: with ena=0 for 20 cycles mid-EVADE, state and timers are frozen; a start edge during the hold is ignored. Asserting rst_n low mid-CLEAN gives state_o=0 and all outputs 0 asynchronously, before the next clk edge.
